// File: rtl/pu_types.sv
// Shared processing-unit types: register index and the default register-file
// and latency-field sizes used by the scoreboard and its neighbours.
package Pu_types;

    localparam int GPR_COUNT  = 32;
    localparam int GPR_LAT_W  = 3;
    localparam int REG_IDX_W  = $clog2(GPR_COUNT);

    typedef logic [REG_IDX_W-1:0] reg_index;

endpackage

// File: rtl/gpr_scoreboard_if.sv
// Decode-side scoreboard bus: issue request, completions, flush, and the
// stall/busy/err responses.
interface gpr_scoreboard_if
    import Pu_types::*;
#(
    parameter int NUM_GPR   = GPR_COUNT,
    parameter int NUM_READ  = 3,
    parameter int NUM_WRITE = 2,
    parameter int LAT_W     = GPR_LAT_W
);
    localparam int IDX_W = $clog2(NUM_GPR);

    logic                                en;
    logic                                issue;
    logic [NUM_READ-1:0]                 rd_valid;
    logic [NUM_READ-1:0][IDX_W-1:0]      rd_idx;
    logic [NUM_WRITE-1:0]                wr_valid;
    logic [NUM_WRITE-1:0][IDX_W-1:0]     wr_idx;
    logic [NUM_WRITE-1:0][LAT_W-1:0]     wr_lat;
    logic [NUM_WRITE-1:0]                cmpl_valid;
    logic [NUM_WRITE-1:0][IDX_W-1:0]     cmpl_idx;
    logic                                flush;
    logic                                stall;
    logic [NUM_GPR-1:0]                  busy;
    logic                                err;

    modport master (
        output en, issue, rd_valid, rd_idx, wr_valid, wr_idx, wr_lat,
               cmpl_valid, cmpl_idx, flush,
        input  stall, busy, err
    );

    modport slave (
        input  en, issue, rd_valid, rd_idx, wr_valid, wr_idx, wr_lat,
               cmpl_valid, cmpl_idx, flush,
        output stall, busy, err
    );

endinterface

// File: rtl/gpr_scoreboard_entry.sv
// One register's reservation: busy flag plus writeback countdown.
// A zero countdown on a busy entry means "wait for explicit completion".
module gpr_scoreboard_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             set,
    input  logic [LAT_W-1:0] set_lat,
    input  logic             cmpl,
    output logic             busy
);
    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (set) begin
            busy <= 1'b1;
            cnt  <= set_lat;
        end else if (cmpl && busy) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (cnt != '0) begin
            // Timer runs independent of enable/stall; last tick releases.
            cnt <= cnt - LAT_W'(1);
            if (cnt == LAT_W'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/gpr_scoreboard.sv
// GPR scoreboard: combinational RAW/WAW stall against registered busy bits,
// reservation per write port, timed or completion-driven release.
module gpr_scoreboard
    import Pu_types::*;
#(
    parameter int NUM_GPR   = GPR_COUNT,
    parameter int NUM_READ  = 3,
    parameter int NUM_WRITE = 2,
    parameter int LAT_W     = GPR_LAT_W
) (
    input  logic             clk,
    input  logic             reset,
    gpr_scoreboard_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_GPR);

    logic [NUM_GPR-1:0]            busy;
    logic [NUM_GPR-1:0]            set;
    logic [NUM_GPR-1:0][LAT_W-1:0] set_lat;
    logic [NUM_GPR-1:0]            cmpl_hit;
    logic                          hazard;
    logic                          do_res;
    logic                          dup_err;
    logic                          cmpl_err;
    logic                          err_q;

    always_comb begin
        hazard = 1'b0;
        for (int g = 0; g < NUM_GPR; g++) begin
            for (int i = 0; i < NUM_READ; i++)
                if (bus.rd_valid[i] && bus.rd_idx[i] == IDX_W'(g) && busy[g])
                    hazard = 1'b1;
            for (int w = 0; w < NUM_WRITE; w++)
                if (bus.wr_valid[w] && bus.wr_idx[w] == IDX_W'(g) && busy[g])
                    hazard = 1'b1;
        end
    end

    assign bus.stall = bus.en & bus.issue & hazard;
    assign do_res    = bus.en & bus.issue & ~hazard & ~bus.flush;

    // Ports aiming at the same register merge; zero latency outranks any count.
    always_comb begin
        set     = '0;
        set_lat = '0;
        dup_err = 1'b0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            for (int g = 0; g < NUM_GPR; g++) begin
                if (do_res && bus.wr_valid[w] && bus.wr_idx[w] == IDX_W'(g)) begin
                    if (set[g]) begin
                        dup_err = 1'b1;
                        if (set_lat[g] != '0 &&
                            (bus.wr_lat[w] == '0 || bus.wr_lat[w] > set_lat[g]))
                            set_lat[g] = bus.wr_lat[w];
                    end else begin
                        set[g]     = 1'b1;
                        set_lat[g] = bus.wr_lat[w];
                    end
                end
            end
        end
    end

    always_comb begin
        cmpl_hit = '0;
        cmpl_err = 1'b0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            for (int g = 0; g < NUM_GPR; g++) begin
                if (bus.cmpl_valid[w] && bus.cmpl_idx[w] == IDX_W'(g)) begin
                    cmpl_hit[g] = 1'b1;
                    if (!busy[g])
                        cmpl_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else if (dup_err || cmpl_err)
            err_q <= 1'b1;
    end

    for (genvar g = 0; g < NUM_GPR; g++) begin : g_entry
        gpr_scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .flush   (bus.flush),
            .set     (set[g]),
            .set_lat (set_lat[g]),
            .cmpl    (cmpl_hit[g]),
            .busy    (busy[g])
        );
    end

    assign bus.busy = busy;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: latency release, completion release,
// WAW/RAW stalls, flush, sticky error and asynchronous reset.
module tb_gpr_scoreboard;
    import Pu_types::*;

    localparam int NUM_GPR   = 32;
    localparam int NUM_READ  = 3;
    localparam int NUM_WRITE = 2;
    localparam int LAT_W     = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpr_scoreboard_if #(
        .NUM_GPR(NUM_GPR), .NUM_READ(NUM_READ), .NUM_WRITE(NUM_WRITE), .LAT_W(LAT_W)
    ) bus ();

    gpr_scoreboard #(
        .NUM_GPR(NUM_GPR), .NUM_READ(NUM_READ), .NUM_WRITE(NUM_WRITE), .LAT_W(LAT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en         = 1'b1;
        bus.issue      = 1'b0;
        bus.rd_valid   = '0;
        bus.rd_idx     = '0;
        bus.wr_valid   = '0;
        bus.wr_idx     = '0;
        bus.wr_lat     = '0;
        bus.cmpl_valid = '0;
        bus.cmpl_idx   = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        bus.issue       = 1'b1;
        bus.rd_valid[0] = 1'b1;
        bus.rd_idx[0]   = 5'd0;
        tick();
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", bus.busy, 32'h0); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        idle();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_raw_latency();
        logic exp;
        idle();
        bus.issue       = 1'b1;
        bus.wr_valid[0] = 1'b1;
        bus.wr_idx[0]   = 5'd5;
        bus.wr_lat[0]   = 3'd3;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got %b exp 0", bus.stall); end
        tick();
        idle();
        bus.issue       = 1'b1;
        bus.rd_valid[0] = 1'b1;
        bus.rd_idx[0]   = 5'd5;
        for (int c = 1; c <= 4; c++) begin
            #1;
            exp = (c <= 3);
            checks++; if (bus.stall !== exp) begin errors++; $display("FAIL raw_stall cyc %0d got %b exp %b", c, bus.stall, exp); end
            if (c == 1) begin
                checks++; if (bus.busy !== 32'h20) begin errors++; $display("FAIL raw_busy got %h exp %h", bus.busy, 32'h20); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_mem_cmpl();
        logic exp;
        idle();
        bus.issue       = 1'b1;
        bus.wr_valid[1] = 1'b1;
        bus.wr_idx[1]   = 5'd7;
        bus.wr_lat[1]   = 3'd0;
        tick();
        idle();
        bus.issue       = 1'b1;
        bus.rd_valid[1] = 1'b1;
        bus.rd_idx[1]   = 5'd7;
        for (int c = 1; c <= 12; c++) begin
            bus.cmpl_valid[0] = (c == 11);
            bus.cmpl_idx[0]   = 5'd7;
            #1;
            exp = (c <= 11);
            checks++; if (bus.busy[7] !== exp) begin errors++; $display("FAIL mem_busy7 cyc %0d got %b exp %b", c, bus.busy[7], exp); end
            checks++; if (bus.stall !== exp) begin errors++; $display("FAIL mem_stall cyc %0d got %b exp %b", c, bus.stall, exp); end
            tick();
        end
        idle();
        #1;
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mem_err got %b exp 0", bus.err); end
    endtask

    task automatic test_waw();
        idle();
        bus.issue       = 1'b1;
        bus.wr_valid[0] = 1'b1;
        bus.wr_idx[0]   = 5'd3;
        bus.wr_lat[0]   = 3'd4;
        tick();
        idle();
        bus.issue       = 1'b1;
        bus.wr_valid[1] = 1'b1;
        bus.wr_idx[1]   = 5'd3;
        bus.wr_lat[1]   = 3'd1;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", bus.stall); end
        idle();
        bus.issue       = 1'b1;
        bus.rd_valid[2] = 1'b1;
        bus.rd_idx[2]   = 5'd4;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_r4_stall got %b exp 0", bus.stall); end
        idle();
        bus.en          = 1'b0;
        bus.issue       = 1'b1;
        bus.wr_valid[0] = 1'b1;
        bus.wr_idx[0]   = 5'd3;
        bus.wr_valid[1] = 1'b1;
        bus.wr_idx[1]   = 5'd10;
        bus.wr_lat[1]   = 3'd2;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL en_low_stall got %b exp 0", bus.stall); end
        tick();
        idle();
        #1;
        checks++; if (bus.busy !== 32'h8) begin errors++; $display("FAIL en_low_busy got %h exp %h", bus.busy, 32'h8); end
        for (int c = 0; c < 3; c++) tick();
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL waw_release got %h exp %h", bus.busy, 32'h0); end
    endtask

    task automatic test_back_to_back();
        idle();
        bus.issue       = 1'b1;
        bus.wr_valid[0] = 1'b1;
        bus.wr_idx[0]   = 5'd2;
        bus.wr_lat[0]   = 3'd1;
        tick();
        bus.wr_idx[0]   = 5'd8;
        bus.wr_lat[0]   = 3'd2;
        #1;
        checks++; if (bus.busy !== 32'h4) begin errors++; $display("FAIL b2b_first got %h exp %h", bus.busy, 32'h4); end
        tick();
        idle();
        #1;
        checks++; if (bus.busy !== 32'h100) begin errors++; $display("FAIL b2b_swap got %h exp %h", bus.busy, 32'h100); end
        tick();
        tick();
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL b2b_release got %h exp %h", bus.busy, 32'h0); end
    endtask

    task automatic test_flush();
        idle();
        bus.issue       = 1'b1;
        bus.wr_valid    = 2'b11;
        bus.wr_idx[0]   = 5'd1;
        bus.wr_lat[0]   = 3'd0;
        bus.wr_idx[1]   = 5'd2;
        bus.wr_lat[1]   = 3'd5;
        tick();
        idle();
        #1;
        checks++; if (bus.busy !== 32'h6) begin errors++; $display("FAIL flush_pre got %h exp %h", bus.busy, 32'h6); end
        bus.flush       = 1'b1;
        bus.issue       = 1'b1;
        bus.wr_valid[0] = 1'b1;
        bus.wr_idx[0]   = 5'd9;
        bus.wr_lat[0]   = 3'd2;
        bus.cmpl_valid[1] = 1'b1;
        bus.cmpl_idx[1]   = 5'd1;
        tick();
        idle();
        #1;
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL flush_busy got %h exp %h", bus.busy, 32'h0); end
        for (int c = 0; c < 4; c++) tick();
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL flush_later got %h exp %h", bus.busy, 32'h0); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", bus.err); end
    endtask

    task automatic test_err();
        idle();
        bus.cmpl_valid[0] = 1'b1;
        bus.cmpl_idx[0]   = 5'd12;
        tick();
        idle();
        #1;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_cmpl got %b exp 1", bus.err); end
        for (int c = 0; c < 3; c++) tick();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.err); end
        do_reset();
        idle();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", bus.err); end
        // Duplicate with timed latencies: larger one (3) wins.
        bus.issue     = 1'b1;
        bus.wr_valid  = 2'b11;
        bus.wr_idx[0] = 5'd6;
        bus.wr_lat[0] = 3'd1;
        bus.wr_idx[1] = 5'd6;
        bus.wr_lat[1] = 3'd3;
        tick();
        idle();
        tick();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_dup got %b exp 1", bus.err); end
        checks++; if (bus.busy !== 32'h40) begin errors++; $display("FAIL dup_maxlat got %h exp %h", bus.busy, 32'h40); end
        tick();
        tick();
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL dup_release got %h exp %h", bus.busy, 32'h0); end
        // Duplicate with zero latency on one port: holds until completion.
        bus.issue     = 1'b1;
        bus.wr_valid  = 2'b11;
        bus.wr_idx[0] = 5'd6;
        bus.wr_lat[0] = 3'd2;
        bus.wr_idx[1] = 5'd6;
        bus.wr_lat[1] = 3'd0;
        tick();
        idle();
        for (int c = 0; c < 5; c++) tick();
        checks++; if (bus.busy !== 32'h40) begin errors++; $display("FAIL dup_zero_hold got %h exp %h", bus.busy, 32'h40); end
        bus.cmpl_valid[1] = 1'b1;
        bus.cmpl_idx[1]   = 5'd6;
        tick();
        idle();
        #1;
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL dup_zero_cmpl got %h exp %h", bus.busy, 32'h0); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_still got %b exp 1", bus.err); end
        do_reset();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.issue       = 1'b1;
        bus.wr_valid[0] = 1'b1;
        bus.wr_idx[0]   = 5'd5;
        bus.wr_lat[0]   = 3'd7;
        tick();
        idle();
        tick();
        bus.issue       = 1'b1;
        bus.rd_valid[0] = 1'b1;
        bus.rd_idx[0]   = 5'd5;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got %b exp 1", bus.stall); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL mid_busy got %h exp %h", bus.busy, 32'h0); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mid_stall got %b exp 0", bus.stall); end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            checks++; if (bus.busy !== 32'h0 || bus.stall !== 1'b0) begin errors++; $display("FAIL mid_after cyc %0d busy %h stall %b exp 0", c, bus.busy, bus.stall); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw_latency();
        test_mem_cmpl();
        test_waw();
        test_back_to_back();
        test_flush();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpr_scoreboard.md
GPR_SCOREBOARD -- requirements
Module: gpr_scoreboard

Interface
REQ-001 SHALL have parameter NUM_GPR, 32, number of tracked general purpose registers.
REQ-002 SHALL have parameter NUM_READ, 3, number of source-operand read ports.
REQ-003 SHALL have parameter NUM_WRITE, 2, number of destination write ports (ALU, memory, ...).
REQ-004 SHALL have parameter LAT_W, 3, width of the per-write latency field; max latency 2**LAT_W-1.
REQ-005 SHALL derive IDX_W = $clog2(NUM_GPR) as a localparam.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them: clk (in, 1, rising-edge clock) and reset (in, 1, asynchronous active-low reset).
REQ-007 en  in  1  enable; when low, stall=0 and no reservations are made; timers keep running.
REQ-008 issue  in  1  decoded instruction presented this cycle.
REQ-009 rd_valid  in  NUM_READ  per-port source read request.
REQ-010 rd_idx  in  NUM_READ*IDX_W  per-port source register index.
REQ-011 wr_valid  in  NUM_WRITE  per-port destination write request.
REQ-012 wr_idx  in  NUM_WRITE*IDX_W  per-port destination register index.
REQ-013 wr_lat  in  NUM_WRITE*LAT_W  cycles until writeback; 0 = release only by explicit completion.
REQ-014 cmpl_valid  in  NUM_WRITE  explicit completion strobe (e.g. memory return).
REQ-015 cmpl_idx  in  NUM_WRITE*IDX_W  register completed.
REQ-016 flush  in  1  discard all outstanding reservations.
REQ-017 stall  out  1  instruction must be held in decode.
REQ-018 busy  out  NUM_GPR  registered reservation vector.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 stall SHALL be combinational: en & issue & (any i: rd_valid[i] & busy[rd_idx[i]] | any w: wr_valid[w] & busy[wr_idx[w]]) (RAW and WAW).
REQ-021 stall SHALL use registered busy only; a release in the current cycle SHALL NOT unstall until the next cycle.
REQ-022 A reservation SHALL occur when en & issue & !stall & !flush; each valid write port sets busy[wr_idx] on the next edge.
REQ-023 A reservation with wr_lat=L>0 SHALL load the register's countdown with L; busy clears on the edge where the count goes 1->0, i.e. busy is high for exactly L cycles.
REQ-024 A reservation with wr_lat=0 SHALL hold busy until a cmpl_valid with matching cmpl_idx; release on the following edge.
REQ-025 Countdowns SHALL decrement every cycle regardless of en and stall.
REQ-026 A completion for a register not busy or counting SHALL be ignored and set err.
REQ-027 Two valid write ports with equal wr_idx in one reservation SHALL set err and reserve once with the larger latency (0 counts as largest).
REQ-028 flush SHALL clear all busy bits and countdowns on the next edge, overriding same-cycle reservations and completions; err is unaffected.
REQ-029 Release and new reservation of different registers in the same cycle SHALL both take effect.
REQ-030 NUM_READ or NUM_WRITE of 1 SHALL be legal; no port may be special-cased.

Reset
REQ-031 Asserting reset SHALL asynchronously clear busy, all countdowns and err; stall therefore reads 0.
REQ-032 Reset mid-countdown SHALL discard the reservation; no release event follows deassertion.

Structure
REQ-033 Reg_index and the default NUM_GPR/LAT_W constants SHALL live in Pu_types; no new package.
REQ-034 One sub-module gpr_scoreboard_entry SHALL hold per-register busy flag and countdown, generated NUM_GPR times.

Verification
REQ-035 Reserve r5 with wr_lat=3, read r5 next cycle -> stall=1 for 3 cycles, 0 on the 4th.
REQ-036 Reserve r7 with wr_lat=0 (mem), cmpl r7 after 10 cycles -> busy[7] high 11 cycles, then 0; RAW on r7 stalls throughout.
REQ-037 Write r3 while r3 counting (WAW) -> stall=1; reads of r4 with no write -> stall=0.
REQ-038 Reserve r1,r2 then flush with a same-cycle reservation of r9 -> busy all 0 next cycle.
REQ-039 cmpl r12 while idle, or both write ports to r6 -> err=1 and stays 1 until reset.
REQ-040 Assert reset during r5 countdown -> busy=0, stall=0 immediately, no later release.
